exe_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, serving the execute stage of the five-stage pipeline. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation at a time over a valid/ready handshake and iterates UNROLL bits per cycle. It writes HI/LO on completion, signals a one-cycle `done`, and supports a pipeline `flush` that aborts an in-flight operation without side effects.

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 34 +++
 rtl/exe_muldiv_unit.sv | 134 +++++++++++++
 tb/tb_exe_muldiv_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide unit:
// opcodes, FSM states and the step-counter width helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Counter must hold XLEN/UNROLL itself, hence the +1.
    function automatic int calc_cnt_w(input int xlen, input int unroll);
        return $clog2(xlen / unroll + 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: shift-add for multiply or
// restoring subtract for divide, selected by mode_div.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode_div,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic          ge;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        sum     = {1'b0, hi_in} + {1'b0, b & {XLEN{lo_in[0]}}};
        shifted = {hi_in, lo_in[XLEN-1]};
        ge      = shifted >= {1'b0, b};
        if (mode_div) begin
            // A restored remainder is always below the divisor, so XLEN bits suffice.
            hi_out = ge ? (shifted[XLEN-1:0] - b) : shifted[XLEN-1:0];
            lo_out = {lo_in[XLEN-2:0], ge};
        end else begin
            hi_out = sum[XLEN:1];
            lo_out = {sum[0], lo_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO for the execute stage.
// Operates on magnitudes, applies signs in FIX, and supports abort via flush.
module exe_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int STEPS = XLEN / UNROLL;
    localparam int CNT_W = calc_cnt_w(XLEN, UNROLL);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [XLEN-1:0]       acc_hi, acc_lo, opnd_b;
    logic                  is_div, neg_q, neg_r, div_zero;
    logic                  accept, op_long, op_signed, op_is_div;
    logic [XLEN-1:0]       abs1, abs2, quo, rem;
    logic [2*XLEN-1:0]     prod, result;
    logic [UNROLL:0][XLEN-1:0] chain_hi, chain_lo;

    always_comb begin
        op_long   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        op_signed = (op == OP_MULT) || (op == OP_DIV);
        op_is_div = (op == OP_DIV) || (op == OP_DIVU);
        abs1      = (op_signed && src1[XLEN-1]) ? -src1 : src1;
        abs2      = (op_signed && src2[XLEN-1]) ? -src2 : src2;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (accept && op_long) state_nxt = ST_CALC;
                ST_CALC: if (cnt == CNT_W'(1))  state_nxt = ST_FIX;
                ST_FIX:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state == ST_IDLE) && !flush;
        busy     = (state != ST_IDLE);
        accept   = in_valid && in_ready;
    end

    assign chain_hi[0] = acc_hi;
    assign chain_lo[0] = acc_lo;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .mode_div (is_div),
            .hi_in    (chain_hi[g]),
            .lo_in    (chain_lo[g]),
            .b        (opnd_b),
            .hi_out   (chain_hi[g+1]),
            .lo_out   (chain_lo[g+1])
        );
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept
    // before the FSM ever reads them, and only HI/LO/done are architectural.
    always_ff @(posedge clk) begin
        if (accept && op_long) begin
            cnt      <= CNT_W'(STEPS);
            acc_hi   <= '0;
            acc_lo   <= op_is_div ? abs1 : abs2;
            opnd_b   <= op_is_div ? abs2 : abs1;
            is_div   <= op_is_div;
            neg_q    <= op_signed && (src1[XLEN-1] ^ src2[XLEN-1]);
            neg_r    <= op_signed && src1[XLEN-1];
            div_zero <= op_is_div && (src2 == '0);
        end else if (state == ST_CALC) begin
            cnt    <= cnt - CNT_W'(1);
            acc_hi <= chain_hi[UNROLL];
            acc_lo <= chain_lo[UNROLL];
        end
    end

    // Divide by zero leaves remainder = |src1|; re-applying src1's sign restores
    // raw src1, so only the quotient needs the bypass.
    always_comb begin
        prod = {acc_hi, acc_lo};
        quo  = div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
        rem  = neg_r ? -acc_hi : acc_hi;
        result = is_div ? {rem, quo} : (neg_q ? -prod : prod);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (accept && !op_long) begin
                if (op == OP_MTHI) hi <= src1;
                if (op == OP_MTLO) lo <= src1;
                done <= 1'b1;
            end else if (state == ST_FIX && !flush) begin
                {hi, lo}    <= result;
                done        <= 1'b1;
                div_by_zero <= div_zero;
            end
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Scoreboard bench for exe_muldiv_unit: three instances (UNROLL 1/2/4) share
// clock/reset; a negedge monitor pops expected HI/LO/div_by_zero/latency on done.
module tb_exe_muldiv_unit;
    import muldiv_pkg::*;

    localparam int NDUT = 3;

    typedef struct {
        int          dut;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        time         t_acc;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [NDUT-1:0]        in_valid = '0;
    logic [NDUT-1:0]        flush = '0;
    logic [NDUT-1:0][2:0]   op = '0;
    logic [NDUT-1:0][31:0]  src1 = '0;
    logic [NDUT-1:0][31:0]  src2 = '0;
    wire  [NDUT-1:0]        in_ready, busy, done, dz;
    wire  [NDUT-1:0][31:0]  hi, lo;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        exe_muldiv_unit #(.XLEN(32), .UNROLL(1 << g)) u_dut (
            .clk         (clk),
            .resetn      (resetn),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .op          (op[g]),
            .src1        (src1[g]),
            .src2        (src2[g]),
            .flush       (flush[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .div_by_zero (dz[g]),
            .hi          (hi[g]),
            .lo          (lo[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every done must match the oldest scoreboard entry of that instance.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (done[d]) begin
                if (sb_q.size() == 0 || sb_q[0].dut != d) begin
                    check($sformatf("spurious_done_u%0d", d), {31'b0, done[d]}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check($sformatf("hi_u%0d", d), hi[d], e.hi);
                    check($sformatf("lo_u%0d", d), lo[d], e.lo);
                    check($sformatf("dz_u%0d", d), {31'b0, dz[d]}, {31'b0, e.dz});
                    check($sformatf("latency_u%0d", d), 32'(int'(($time - e.t_acc) / 10)), 32'(e.lat));
                end
            end
        end
    end

    // Entered and left at posedge+1; presents the op until in_ready, then drops it.
    task automatic issue(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic edz, input int elat, output time t_acc);
        exp_t e;
        bit   ok = 1'b0;
        in_valid[d] = 1'b1;
        op[d]   = o;
        src1[d] = a;
        src2[d] = b;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready[d]) ok = 1'b1;
        end
        t_acc = $time;
        if (!ok) begin
            check("accept_timeout", {31'b0, in_ready[d]}, 32'd1);
        end else if (track) begin
            e.dut = d; e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat; e.t_acc = t_acc;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        while (sb_q.size() != 0 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run(input int d, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int elat);
        time t;
        issue(d, o, a, b, 1'b1, ehi, elo, edz, elat, t);
        drain();
    endtask

    task automatic check_reset_state(input int d, input string tag);
        check($sformatf("%s_in_ready_u%0d", tag, d), {31'b0, in_ready[d]}, 32'd1);
        check($sformatf("%s_busy_u%0d", tag, d), {31'b0, busy[d]}, 32'd0);
        check($sformatf("%s_done_u%0d", tag, d), {31'b0, done[d]}, 32'd0);
        check($sformatf("%s_dz_u%0d", tag, d), {31'b0, dz[d]}, 32'd0);
        check($sformatf("%s_hi_u%0d", tag, d), hi[d], 32'd0);
        check($sformatf("%s_lo_u%0d", tag, d), lo[d], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        time t1, t2, tx;

        repeat (3) @(posedge clk); #1;
        for (int d = 0; d < NDUT; d++) check_reset_state(d, "por");
        resetn = 1'b1;
        @(posedge clk); #1;

        // UNROLL=1: multiply/divide directed vectors, latency 34
        run(0, OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34);
        run(0, OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 34);
        run(0, OP_DIVU,  32'd100,       32'd7, 32'd2,         32'd14,        1'b0, 34);
        run(0, OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        run(0, OP_DIVU,  32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF, 1'b1, 34);
        run(0, OP_DIV,   32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 34);
        run(0, OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);

        // Flush mid-multiply: no write, no done, unit idle right after
        issue(0, OP_MULT, 32'd7, 32'd9, 1'b0, 32'd0, 32'd0, 1'b0, 0, tx);
        repeat (9) @(posedge clk); #1;
        flush[0] = 1'b1;
        @(negedge clk);
        check("flush_blocks_ready", {31'b0, in_ready[0]}, 32'd0);
        @(posedge clk); #1;
        flush[0] = 1'b0;
        @(negedge clk);
        check("flush_busy", {31'b0, busy[0]}, 32'd0);
        check("flush_in_ready", {31'b0, in_ready[0]}, 32'd1);
        check("flush_hi_kept", hi[0], 32'd0);
        check("flush_lo_kept", lo[0], 32'h8000_0000);
        repeat (40) @(negedge clk);
        @(posedge clk); #1;
        run(0, OP_MTLO, 32'h0000_1234, 32'd0, 32'd0, 32'h0000_1234, 1'b0, 1);
        run(0, OP_NOP,  32'hDEAD_BEEF, 32'd3, 32'd0, 32'h0000_1234, 1'b0, 1);

        // MTHI then MULTU accepted in the done cycle
        issue(0, OP_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b1, 32'hA5A5_A5A5, 32'h0000_1234, 1'b0, 1, t1);
        issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, t2);
        check("back_to_back_gap", 32'(int'(t2 - t1)), 32'd10);
        drain();

        // Reset in the middle of a divide
        issue(0, OP_DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0, tx);
        repeat (5) @(posedge clk); #1;
        resetn = 1'b0;
        #2;
        check_reset_state(0, "midrst");
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run(0, OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34);

        // UNROLL=2 and UNROLL=4
        run(1, OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 18);
        run(1, OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 18);
        run(1, OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 18);
        run(2, OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 10);
        run(2, OP_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0000_0004, 32'hFFFF_FFF1, 1'b0, 10);
        run(2, OP_DIVU,  32'd100,       32'd7, 32'd2,         32'd14,        1'b0, 10);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
